mdu_hilo: RTL
=============

# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS32 core. It executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle sequence and also services MTHI/MTLO writes. It sits directly upstream of the write-back result-select 4:1 multiplexer, which picks among ALU result, memory data, HI and LO; `hi` and `lo` are its two HI/LO inputs.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation in `op` on operands `a`, `b`.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand or dividend (rs).
- `b`  in  WIDTH  multiplier or divisor (rt).
- `mthi`  in  1  write `wdata` into HI.
- `mtlo`  in  1  write `wdata` into LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress; the core stalls MFHI/MFLO while this is high.
- `done`  out  1  single-cycle pulse: HI/LO hold the new result.
- `hi`  out  WIDTH  HI register (product upper half or remainder).
- `lo`  out  WIDTH  LO register (product lower half or quotient).

## Operation
- FSM states and transitions:
  - IDLE goes to RUN on `start`.
  - RUN lasts 32 iterations, then goes to FIX.
  - FIX goes to DONE.
  - DONE goes to IDLE, or to RUN if `start` is high.
- `start` is accepted only in IDLE or DONE. It is ignored in RUN and FIX.
- On accept:
  - Latch magnitudes |a| and |b|; signed ops only, unsigned ops use the raw values.
  - Latch sign flags sa and sb, plus `op`.
  - Clear the 6-bit iteration counter.
- Multiply:
  - Unsigned shift-add, one multiplier bit per RUN cycle, into a 64-bit accumulator.
  - In FIX, negate the 64-bit product when the op is signed and sa^sb is set.
- Divide:
  - Restoring division, one quotient bit per RUN cycle, using a 33-bit trial subtract.
  - In FIX (signed only), the quotient is negated when sa^sb is set.
  - In FIX (signed only), the remainder is negated when sa is set.
  - Remainder goes to HI, quotient to LO.
- Divide by zero (b==0, DIV or DIVU):
  - LO = all ones, HI = `a` unmodified, with no sign fix.
  - Sequence length is unchanged.
- 0x80000000 / -1 (DIV) gives LO = 0x80000000 and HI = 0. This is the natural wrap and is not flagged.
- HI/LO are written only at the FIX→DONE edge, or by MTHI/MTLO.
- MTHI/MTLO:
  - Take effect at the next edge when `busy` is low.
  - Ignored while `busy` is high.
  - If MTHI/MTLO coincides with an accepted `start`, the write lands now and the result later overwrites it.
- `busy` = state is RUN or FIX. `done` = state is DONE.

## Timing
- Reset, asynchronous:
  - State goes to IDLE.
  - `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.
  - Internal accumulator and counter are cleared.
- Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- Edge 0 samples `start`.
- `busy` is high in cycles 1–33: 32 RUN cycles plus 1 FIX cycle.
- Edge 33 updates HI/LO.
- `done` is high in cycle 34 only.
- Back-to-back: `start` in cycle 34 is accepted at edge 34, so `busy` rises again in cycle 35.
- Fixed latency: 34 cycles from `start` sample to `done`, independent of operand values.
- Operands `a`, `b`, `op` are sampled only at accept; they may change afterward.

## Structure
- Package `mdu_pkg` holds:
  - Op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
  - FSM state encoding (IDLE, RUN, FIX, DONE).
  - `MDU_ITER` = 32.
- One sub-module, `mdu_step`: combinational single iteration, i.e. shift-add or trial-subtract/shift selected by a mul/div flag, operating on the {rem/hi, lo} pair.
- The top holds the FSM, counter, sign flags, FIX negation, HI/LO registers and MT writes.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → at `done`: hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 → hi=2, lo=14.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234; `done` still arrives at cycle 34.
- MTHI 0xAAAA while idle → hi=0xAAAA next cycle. MTLO and a second `start` during RUN → both ignored; lo and the result reflect the first op only.
- `rst_n` pulsed low at cycle 15 of a MULT → hi=lo=0, `busy`=`done`=0 immediately. A new `start` after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and iteration count for the HI/LO multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    localparam int MDU_ITER = 32;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - core-side command/result bundle of the HI/LO multiply/divide unit
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational iteration: shift-add multiply or restoring-divide step on {hi, lo}
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] trial;
    logic             ge;

    always_comb begin
        sum    = {1'b0, hi_in} + {1'b0, opnd};
        rem_sh = {hi_in, lo_in[WIDTH-1]};
        // When rem_sh >= opnd the difference is below opnd, so the low WIDTH bits are exact.
        trial  = rem_sh[WIDTH-1:0] - opnd;
        ge     = rem_sh >= {1'b0, opnd};
        hi_out = hi_in;
        lo_out = lo_in;
        if (is_div) begin
            hi_out = ge ? trial : rem_sh[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], ge};
        end else if (lo_in[0]) begin
            {hi_out, lo_out} = {sum, lo_in[WIDTH-1:1]};
        end else begin
            {hi_out, lo_out} = {1'b0, hi_in, lo_in[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_hilo_if.slave   bus
);
    localparam logic [5:0] LAST_ITER = 6'(MDU_ITER - 1);

    mdu_state_e       state, state_n;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic             sa, sb, is_div_q, div_zero;
    logic             accept, busy;
    logic             in_signed, in_div, in_sa, in_sb;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix, res_hi, res_lo;

    assign busy   = (state == ST_RUN) || (state == ST_FIX);
    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

    assign in_signed = op_is_signed(bus.op);
    assign in_div    = op_is_div(bus.op);
    assign in_sa     = in_signed && bus.a[WIDTH-1];
    assign in_sb     = in_signed && bus.b[WIDTH-1];
    assign a_abs     = in_sa ? -bus.a : bus.a;
    assign b_abs     = in_sb ? -bus.b : bus.b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .hi_in  (acc_hi),
        .lo_in  (acc_lo),
        .opnd   (opnd),
        .hi_out (hi_nx),
        .lo_out (lo_nx)
    );

    // sa/sb are only ever set for signed ops, so they double as the signed-fix enables.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (sa ^ sb) ? -prod : prod;
        q_fix    = (sa ^ sb) ? -acc_lo : acc_lo;
        r_fix    = sa ? -acc_hi : acc_hi;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            res_hi = div_zero ? a_q : r_fix;
            res_lo = div_zero ? '1 : q_fix;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_RUN;
            ST_RUN:  if (cnt == LAST_ITER) state_n = ST_FIX;
            ST_FIX:  state_n = ST_DONE;
            ST_DONE: state_n = accept ? ST_RUN : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_q      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            is_div_q <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                acc_hi   <= '0;
                acc_lo   <= in_div ? a_abs : b_abs;
                opnd     <= in_div ? b_abs : a_abs;
                a_q      <= bus.a;
                sa       <= in_sa;
                sb       <= in_sb;
                is_div_q <= in_div;
                div_zero <= (bus.b == '0);
            end else if (state == ST_RUN) begin
                acc_hi <= hi_nx;
                acc_lo <= lo_nx;
                cnt    <= cnt + 6'd1;
            end

            if (state == ST_FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (!busy) begin
                if (bus.mthi) hi_q <= bus.wdata;
                if (bus.mtlo) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = (state == ST_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
